uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among `NUM_REQ` byte producers. It accepts one byte per grant and drives the transmitter's data/start inputs. It then holds the byte until the transmitter reports completion, or until a watchdog expires. It sits between the producer blocks and the UART_tx instance, replacing the direct receive-to-transmit loopback when several sources must transmit.

---
 rtl/uart_tx_arbiter.sv | 66 ++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_err,
  input  logic                 err_clr
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  state_t state, state_nxt;
  logic [2:0] last, pick;
  logic hit, expire;
  logic [23:0] cnt;
  always_comb begin
    hit = 1'b0;
    pick = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      if (|(req & (NUM_REQ'(1) << ((int'(last) + i) % NUM_REQ)))) begin
        hit = 1'b1;
        pick = 3'((int'(last) + i) % NUM_REQ);
      end
  end
  assign expire = state == WAIT && !tx_done && cnt == TIMEOUT_CYCLES - 24'd1;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (hit ? LOAD : IDLE) :
                state == LOAD ? WAIT :
                (tx_done || expire) ? IDLE : WAIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last <= 3'(NUM_REQ - 1);
      owner <= '0;
      tx_data <= '0;
      gnt <= '0;
      tx_start <= 1'b0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      gnt <= '0;
      tx_start <= 1'b0;
      if (state == IDLE && hit) begin
        last <= pick;
        owner <= pick;
        tx_data <= 8'(req_data >> {pick, 3'b000});
        gnt <= NUM_REQ'(1) << pick;
        tx_start <= 1'b1;
      end
      cnt <= state == WAIT ? cnt + 24'd1 : '0;
      timeout_err <= expire | (timeout_err & ~err_clr);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table plus scoreboarded corner sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk, rst, tx_start, tx_done, busy, timeout_err, err_clr;
  logic [3:0] req, gnt;
  logic [31:0] req_data;
  logic [7:0] tx_data;
  logic [2:0] owner;
  int n_cmp, n_bad, n;
  typedef struct {
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] gnt;
    logic [7:0] txd;
    logic [2:0] own;
    int dly;
  } vec_t;
  typedef struct {
    logic [3:0] gnt;
    logic [7:0] txd;
    logic [2:0] own;
  } exp_t;
  vec_t tv[8];
  exp_t sb[$];
  exp_t e;
  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(24'd64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy),
    .owner(owner), .timeout_err(timeout_err), .err_clr(err_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      tx_done = 1'b0;
      cyc++;
    end while (!tx_start && cyc < 200);
    chk("start_seen", {31'd0, tx_start}, 1);
  endtask
  task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [2:0] o);
    sb.push_back('{g, d, o});
  endtask
  always @(negedge clk)
    if (tx_start) begin
      if (sb.size() == 0) chk("sb_unexpected_start", {31'd0, tx_start}, 0);
      else begin
        e = sb.pop_front();
        chk("sb_gnt", {28'd0, gnt}, {28'd0, e.gnt});
        chk("sb_tx_data", {24'd0, tx_data}, {24'd0, e.txd});
        chk("sb_owner", {29'd0, owner}, {29'd0, e.own});
        chk("sb_busy_in_load", {31'd0, busy}, 1);
      end
    end
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end
  initial begin
    n_cmp = 0;
    n_bad = 0;
    tv[0] = '{4'b0100, 32'h11A52233, 4'b0100, 8'hA5, 3'd2, 10};
    tv[1] = '{4'b1010, 32'h5A446677, 4'b1000, 8'h5A, 3'd3, 3};
    tv[2] = '{4'b1010, 32'h0102C304, 4'b0010, 8'hC3, 3'd1, 1};
    tv[3] = '{4'b0001, 32'h0000007E, 4'b0001, 8'h7E, 3'd0, 5};
    tv[4] = '{4'b1001, 32'h81000018, 4'b1000, 8'h81, 3'd3, 2};
    tv[5] = '{4'b1001, 32'h81000018, 4'b0001, 8'h18, 3'd0, 7};
    tv[6] = '{4'b0110, 32'h009CE700, 4'b0010, 8'hE7, 3'd1, 4};
    tv[7] = '{4'b0110, 32'h009CE700, 4'b0100, 8'h9C, 3'd2, 1};
    rst = 1'b1;
    req = '0;
    req_data = '0;
    tx_done = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 0);
    chk("rst_tx_start", {31'd0, tx_start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_owner", {29'd0, owner}, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      req = tv[i].req;
      req_data = tv[i].data;
      push(tv[i].gnt, tv[i].txd, tv[i].own);
      wait_start(n);
      chk("grant_latency", n, 1);
      req = '0;
      @(negedge clk);
      chk("start_one_cycle", {31'd0, tx_start}, 0);
      chk("gnt_one_cycle", {28'd0, gnt}, 0);
      chk("tx_data_hold", {24'd0, tx_data}, {24'd0, tv[i].txd});
      repeat (tv[i].dly - 1) @(negedge clk);
      tx_done = 1'b1;
      chk("busy_in_wait", {31'd0, busy}, 1);
      @(negedge clk);
      tx_done = 1'b0;
      chk("busy_after_done", {31'd0, busy}, 0);
    end
    req = 4'b0001;
    req_data = 32'h0000005C;
    push(4'b0001, 8'h5C, 3'd0);
    wait_start(n);
    req = '0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("load_done_ignored", {31'd0, busy}, 1);
    @(negedge clk);
    chk("still_waiting", {31'd0, busy}, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("busy_after_done", {31'd0, busy}, 0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle_done_busy", {31'd0, busy}, 0);
    chk("idle_done_start", {31'd0, tx_start}, 0);
    req = 4'b1100;
    req_data = 32'h99880000;
    push(4'b0100, 8'h88, 3'd2);
    push(4'b1000, 8'h99, 3'd3);
    wait_start(n);
    req = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!timeout_err && n < 200);
    chk("timeout_latency", n, 65);
    chk("timeout_idle", {31'd0, busy}, 0);
    @(negedge clk);
    chk("regrant_after_timeout", {31'd0, tx_start}, 1);
    req = '0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, timeout_err}, 0);
    repeat (63) @(negedge clk);
    chk("busy_last_wait", {31'd0, busy}, 1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("done_last_cycle_idle", {31'd0, busy}, 0);
    chk("done_wins_no_err", {31'd0, timeout_err}, 0);
    req = 4'b0001;
    req_data = 32'h000000E1;
    push(4'b0001, 8'hE1, 3'd0);
    wait_start(n);
    req = '0;
    repeat (64) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("set_wins_over_clr", {31'd0, timeout_err}, 1);
    chk("set_wins_idle", {31'd0, busy}, 0);
    req = 4'b0100;
    req_data = 32'h00F00000;
    push(4'b0100, 8'hF0, 3'd2);
    wait_start(n);
    req = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_gnt", {28'd0, gnt}, 0);
    chk("arst_tx_start", {31'd0, tx_start}, 0);
    chk("arst_tx_data", {24'd0, tx_data}, 0);
    chk("arst_owner", {29'd0, owner}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_timeout_err", {31'd0, timeout_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    req_data = 32'hD3C2B1A0;
    for (int k = 0; k < 6; k++) push(4'b0001 << (k % 4), 8'(req_data >> (8 * (k % 4))), 3'(k % 4));
    for (int k = 0; k < 6; k++) begin
      wait_start(n);
      if (k > 0) chk("fair_gap_after_done", n, 2);
      else chk("grant_latency", n, 1);
      if (k == 5) req = '0;
      repeat (10) @(negedge clk);
      tx_done = 1'b1;
    end
    @(negedge clk);
    tx_done = 1'b0;
    chk("final_idle", {31'd0, busy}, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
